// File: rtl/lane_sequencer.sv
// lane_sequencer: rhythm-game controller stepping LFSR-spawned notes down a 4-lane grid and judging hits.
module lane_sequencer #(
  parameter int ROWS = 8,
  parameter int TICK_DIV = 25000000,
  parameter logic [7:0] SEED = 8'hA5,
  parameter int MISS_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        hit,
  output logic [4*ROWS-1:0] field,
  output logic [7:0]        score,
  output logic [2:0]        misses,
  output logic              playing,
  output logic              game_over,
  output logic              soft_reset
);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, CLEAR, PLAY, OVER} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [7:0] lfsr, lfsr_n, score_n;
  logic [2:0] misses_n;
  logic [4*ROWS-1:0] field_n, kept;
  logic [3:0] bottom, good, wrong, fall, spawn;
  logic [8:0] score_sum;
  logic [4:0] miss_sum;
  logic step;
  function automatic logic [2:0] ones(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
  always_comb begin
    bottom = field[4*ROWS-1 -: 4];
    step = tick == TW'(TICK_DIV - 1);
    good = hit & bottom;
    wrong = hit & ~bottom;
    // hits are judged before the shift, so a struck note can never also fall off
    kept = field & ~{good, {4*(ROWS-1){1'b0}}};
    fall = step ? kept[4*ROWS-1 -: 4] : 4'd0;
    spawn = lfsr[7] ? 4'd1 << lfsr[1:0] : 4'd0;
    score_sum = {1'b0, score} + {6'd0, ones(good)};
    miss_sum = {2'b0, misses} + {2'b0, ones(wrong)} + {2'b0, ones(fall)};
    state_n = state;
    field_n = field;
    score_n = score;
    misses_n = misses;
    tick_n = tick;
    lfsr_n = lfsr;
    case (state)
      IDLE: begin
        field_n = '0;
        state_n = start ? CLEAR : IDLE;
      end
      CLEAR: begin
        field_n = '0;
        score_n = '0;
        misses_n = '0;
        tick_n = '0;
        lfsr_n = SEED;
        state_n = PLAY;
      end
      PLAY: begin
        field_n = step ? {kept[4*ROWS-5:0], spawn} : kept;
        score_n = score_sum[8] ? 8'hFF : score_sum[7:0];
        misses_n = miss_sum > 5'd7 ? 3'd7 : miss_sum[2:0];
        tick_n = step ? '0 : tick + 1'b1;
        lfsr_n = step ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]} : lfsr;
        state_n = {29'd0, misses_n} >= MISS_LIMIT ? OVER : PLAY;
      end
      OVER: state_n = start ? CLEAR : OVER;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      field <= '0;
      score <= '0;
      misses <= '0;
      tick <= '0;
      lfsr <= SEED;
    end else begin
      state <= state_n;
      field <= field_n;
      score <= score_n;
      misses <= misses_n;
      tick <= tick_n;
      lfsr <= lfsr_n;
    end
  end
  assign playing = state == PLAY;
  assign game_over = state == OVER;
  assign soft_reset = state == CLEAR;
endmodule

// File: tb/tb_lane_sequencer.sv
// tb_lane_sequencer: scoreboarded bench for lane_sequencer with ROWS=4, TICK_DIV=4, SEED=A5, MISS_LIMIT=4.
module tb_lane_sequencer;
  logic clk = 0, reset = 0, start = 0;
  logic [3:0] hit = 0;
  logic [15:0] field;
  logic [7:0] score;
  logic [2:0] misses;
  logic playing, game_over, soft_reset;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [15:0] f;
    logic [7:0] sc;
    logic [2:0] m;
    logic p;
    logic g;
    logic sr;
  } exp_t;
  exp_t q[$];
  int ms = 0, msc = 0, mm = 0, mt = 0;
  logic [15:0] mf = 0;
  logic [7:0] ml = 8'hA5;

  lane_sequencer #(.ROWS(4), .TICK_DIV(4), .SEED(8'hA5), .MISS_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .hit(hit), .field(field), .score(score),
    .misses(misses), .playing(playing), .game_over(game_over), .soft_reset(soft_reset)
  );

  always #5 clk = ~clk;

  // reference: states 0 idle, 1 clear, 2 play, 3 over
  task automatic model(input logic [3:0] h, input logic s, input logic r);
    if (r) begin
      ms = 0; mf = 0; msc = 0; mm = 0; mt = 0; ml = 8'hA5;
    end else if (ms == 0 || ms == 3) begin
      if (s) ms = 1;
    end else if (ms == 1) begin
      mf = 0; msc = 0; mm = 0; mt = 0; ml = 8'hA5; ms = 2;
    end else begin
      for (int l = 0; l < 4; l++)
        if (h[l]) begin
          if (mf[12+l]) begin mf[12+l] = 1'b0; msc++; end
          else mm++;
        end
      if (mt == 3) begin
        for (int l = 0; l < 4; l++) if (mf[12+l]) mm++;
        mf = mf << 4;
        if (ml[7]) mf[ml[1:0]] = 1'b1;
        ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
        mt = 0;
      end else mt++;
      if (msc > 255) msc = 255;
      if (mm > 7) mm = 7;
      if (mm >= 4) ms = 3;
    end
  endtask

  task automatic cycle(input logic [3:0] h, input logic s);
    exp_t e;
    hit = h;
    start = s;
    model(h, s, reset);
    q.push_back('{mf, 8'(msc), 3'(mm), ms == 2, ms == 3, ms == 1});
    @(posedge clk);
    #1;
    hit = 0;
    start = 0;
    e = q.pop_front();
    checks += 6;
    if (field !== e.f) begin errors++; $display("FAIL sb_field t=%0t got %h want %h", $time, field, e.f); end
    if (score !== e.sc) begin errors++; $display("FAIL sb_score t=%0t got %0d want %0d", $time, score, e.sc); end
    if (misses !== e.m) begin errors++; $display("FAIL sb_misses t=%0t got %0d want %0d", $time, misses, e.m); end
    if (playing !== e.p) begin errors++; $display("FAIL sb_playing t=%0t got %b want %b", $time, playing, e.p); end
    if (game_over !== e.g) begin errors++; $display("FAIL sb_game_over t=%0t got %b want %b", $time, game_over, e.g); end
    if (soft_reset !== e.sr) begin errors++; $display("FAIL sb_soft_reset t=%0t got %b want %b", $time, soft_reset, e.sr); end
  endtask

  task automatic test_reset;
    reset = 1;
    cycle(4'h0, 1'b1);
    cycle(4'hF, 1'b0);
    checks++;
    if ({field, score, misses, playing, game_over, soft_reset} !== 30'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {field, score, misses, playing, game_over, soft_reset});
    end
    reset = 0;
    cycle(4'hF, 1'b0);
    checks++;
    if (playing !== 1'b0 || field !== 16'h0) begin errors++; $display("FAIL idle_hit got playing=%b field=%h want 0", playing, field); end
  endtask

  task automatic test_start;
    cycle(4'h0, 1'b1);
    checks++;
    if (soft_reset !== 1'b1 || playing !== 1'b0) begin errors++; $display("FAIL clear_pulse got sr=%b p=%b want 1 0", soft_reset, playing); end
    cycle(4'h0, 1'b0);
    checks++;
    if (soft_reset !== 1'b0 || playing !== 1'b1 || field !== 16'h0 || score !== 8'd0 || misses !== 3'd0) begin
      errors++; $display("FAIL play_entry got sr=%b p=%b f=%h s=%0d m=%0d want 0 1 0 0 0", soft_reset, playing, field, score, misses);
    end
  endtask

  task automatic test_steps;
    logic [15:0] want [4];
    want[0] = 16'h0002; want[1] = 16'h0020; want[2] = 16'h0202; want[3] = 16'h2020;
    for (int k = 0; k < 4; k++) begin
      repeat (3) cycle(4'h0, 1'b0);
      checks++;
      if (field !== (k == 0 ? 16'h0 : want[k-1])) begin errors++; $display("FAIL pre_step%0d got %h", k, field); end
      cycle(4'h0, 1'b0);
      checks++;
      if (field !== want[k]) begin errors++; $display("FAIL step%0d got %h want %h", k, field, want[k]); end
    end
  endtask

  task automatic test_hit;
    int n = 0;
    cycle(4'b0010, 1'b0);
    checks++;
    if (field !== 16'h0020 || score !== 8'd1 || misses !== 3'd0) begin
      errors++; $display("FAIL hit_bottom got f=%h s=%0d m=%0d want 0020 1 0", field, score, misses);
    end
    while (!(mt == 3 && mf[15:12] != 0) && n < 100) begin cycle(4'h0, 1'b0); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL timeout_step_hit got %0d cycles want <100", n); end
    cycle(mf[15:12], 1'b0);
    checks++;
    if (score !== 8'd2 || misses !== 3'd0 || field[15:12] !== 4'h0) begin
      errors++; $display("FAIL hit_on_step got s=%0d m=%0d bot=%h want 2 0 0", score, misses, field[15:12]);
    end
  endtask

  task automatic test_wrong;
    int n = 0;
    while (mf[15:12] != 0 && n < 100) begin cycle(mf[15:12], 1'b0); n++; end
    cycle(4'b1001, 1'b0);
    checks++;
    if (misses !== 3'd2 || score !== 8'd2) begin errors++; $display("FAIL double_wrong got m=%0d s=%0d want 2 2", misses, score); end
    n = 0;
    while (mm == 2 && n < 200) begin cycle(4'h0, 1'b0); n++; end
    checks++;
    if (misses !== 3'd3 || playing !== 1'b1) begin errors++; $display("FAIL fall_off got m=%0d p=%b want 3 1", misses, playing); end
  endtask

  task automatic test_over;
    logic [15:0] fz;
    logic [3:0] h;
    h = mf[12] ? 4'b0010 : 4'b0001;
    cycle(h, 1'b0);
    checks++;
    if (game_over !== 1'b1 || playing !== 1'b0 || misses !== 3'd4) begin
      errors++; $display("FAIL game_end got g=%b p=%b m=%0d want 1 0 4", game_over, playing, misses);
    end
    fz = mf;
    for (int i = 0; i < 20; i++) begin
      cycle(4'($urandom_range(0, 15)), 1'b0);
      checks++;
      if (field !== fz || game_over !== 1'b1 || score !== 8'd2) begin
        errors++; $display("FAIL over_frozen got f=%h g=%b s=%0d want %h 1 2", field, game_over, score, fz);
      end
    end
    test_start;
  endtask

  task automatic test_miss_sat;
    int n = 0;
    while (!(mm == 3 && mf[15:12] == 0) && n < 200) begin
      cycle(mf[15:12] != 0 ? mf[15:12] : (mm < 3 ? 4'b0001 : 4'b0000), 1'b0);
      n++;
    end
    cycle(4'hF, 1'b0);
    checks++;
    if (misses !== 3'd7 || game_over !== 1'b1) begin errors++; $display("FAIL miss_sum4 got m=%0d g=%b want 7 1", misses, game_over); end
    test_start;
  endtask

  task automatic test_score_sat;
    int n = 0;
    while (msc < 255 && n < 20000) begin cycle(mf[15:12], 1'b0); n++; end
    repeat (40) cycle(mf[15:12], 1'b0);
    checks++;
    if (score !== 8'd255 || misses !== 3'd0) begin errors++; $display("FAIL score_sat got s=%0d m=%0d want 255 0", score, misses); end
    cycle(4'h0, 1'b1);
    checks++;
    if (playing !== 1'b1 || soft_reset !== 1'b0) begin errors++; $display("FAIL start_in_play got p=%b sr=%b want 1 0", playing, soft_reset); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    reset = 1;
    cycle(4'h0, 1'b0);
    reset = 0;
    test_start;
    while (msc < 2 && n < 500) begin cycle(mf[15:12], 1'b0); n++; end
    checks++;
    if (score !== 8'd2 || playing !== 1'b1) begin errors++; $display("FAIL reach_score2 got s=%0d p=%b want 2 1", score, playing); end
    reset = 1;
    cycle(4'h3, 1'b1);
    reset = 0;
    checks++;
    if ({field, score, misses, playing, game_over, soft_reset} !== 30'd0) begin
      errors++; $display("FAIL reset_mid got %h want 0", {field, score, misses, playing, game_over, soft_reset});
    end
    test_start;
    repeat (4) cycle(4'h0, 1'b0);
    checks++;
    if (field !== 16'h0002) begin errors++; $display("FAIL respawn got %h want 0002", field); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_steps;
    test_hit;
    test_wrong;
    test_over;
    test_miss_sat;
    test_score_sat;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
